approx_err_sweeper: RTL and testbench
=====================================

# approx_err_sweeper

Sequencer that exhaustively drives every input vector into a generated approximate circuit and its exact counterpart side by side. It compares their outputs as unsigned integers, tracks worst-case absolute error and the number of vectors exceeding the error threshold, and reports pass/fail against that threshold. It sits on the evaluation bench around any combinational SOP/shared-logic netlist produced by the flow, for example a 4-input, 2-output `abs_diff` instance checked at et=1.

## Interface
- `N_IN`, default 4: input width of the circuits under evaluation; the sweep covers 2^N_IN vectors.
- `N_OUT`, default 2: output width of the circuits under evaluation; outputs are read as unsigned integers.
- `ET`, default 1: error threshold. A vector violates when its error is greater than ET.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request a sweep. Sampled only in IDLE.
- `abort` input 1: synchronous stop. Returns to IDLE from any non-IDLE state.
- `vec_out` output N_IN: vector driven to both circuits. Registered.
- `exact_in` input N_OUT: output of the exact circuit for `vec_out`. Combinational return path.
- `approx_in` input N_OUT: output of the approximate circuit for `vec_out`. Combinational return path.
- `busy` output 1: high in SWEEP, DRAIN and DONE.
- `done` output 1: one-cycle pulse; results are final while it is high.
- `max_err` output N_OUT: maximum of |exact − approx| over the vectors evaluated so far.
- `viol_cnt` output N_IN+1: number of violating vectors. Holds a value up to 2^N_IN.
- `first_viol` output N_IN: lowest-numbered violating vector.
- `viol_seen` output 1: qualifies `first_viol`.
- `pass` output 1: high when `viol_cnt` is 0. Meaningful from `done` until the next accepted start.

## Operation
- Reset values: all outputs are 0, including `pass`. State is IDLE.
- **IDLE**
  - `start`=1 and `abort`=0 → go to SWEEP.
  - On that same edge: `vec_out` is set to 0, and `max_err`, `viol_cnt`, `viol_seen`, `first_viol` and `pass` are cleared to 0.
  - `start` and `abort` both high in IDLE: `abort` wins and the block stays in IDLE.
- **SWEEP**
  - Each cycle, `exact_in`, `approx_in` and the current `vec_out` are registered into stage 1, then `vec_out` increments.
  - When `vec_out` = 2^N_IN−1 is captured, go to DRAIN. `vec_out` wraps to 0 and holds there.
  - `start` is ignored while busy.
- **Stage 2 accumulate** (valid-tagged, one cycle after stage 1)
  - err = |e − a|, computed at N_OUT bits with no overflow. Take the larger operand minus the smaller.
  - `max_err` ← max(`max_err`, err).
  - If err > ET: `viol_cnt` increments. If `viol_seen`=0, set `first_viol` ← tag and `viol_seen` ← 1.
- **DRAIN**: one cycle to accumulate the last vector, then go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle.
  - `pass` ← (`viol_cnt`==0), registered at DRAIN→DONE so it is valid together with `done`.
  - Then go to IDLE. Results hold until the next accepted start.
- **Abort** in SWEEP, DRAIN or DONE
  - Next state is IDLE. The stage-1 valid bit is cleared and `vec_out` is set to 0.
  - `done` does not pulse. `pass` stays 0.
  - Partial `max_err`, `viol_cnt` and `first_viol` are left visible.
- **Reset mid-operation**: immediate return to the reset values; no `done` pulse.
- **Counter width**: `viol_cnt` is N_IN+1 bits, so the all-fail case reads 2^N_IN. It must not wrap to 0.

## Timing
- Call the edge that accepts `start` E0.
- Vector k is presented from E0+k to E0+k+1. It is captured at E0+k+1 and accumulated at E0+k+2.
- The last vector is accumulated at E0+2^N_IN+1.
- `done` is high in the cycle following E0+2^N_IN+1. For N_IN=4 that is the 18th cycle after E0.
- `busy` goes high after E0 and low after the DONE cycle: 2^N_IN+2 cycles in total.
- A new `start` can be accepted in the first IDLE cycle after DONE. Back-to-back sweeps therefore have a period of 2^N_IN+3 cycles.
- The return path is combinational. The circuits under evaluation must settle within one clock period.

## Test plan
- **Identity**: `approx_in` = `exact_in` = `vec_out`[1:0] with defaults → `done` at the 18th cycle after E0; `max_err`=0, `viol_cnt`=0, `viol_seen`=0, `pass`=1.
- **All fail**: `exact_in` stuck at 3, `approx_in` stuck at 0 → `max_err`=3, `viol_cnt`=16 (not 0), `first_viol`=0, `pass`=0.
- **Single fault**:
  - Model: `approx_in` = `exact_in`, except at vector 9 where exact=2 and approx=0.
  - Required result: `max_err`=2, `viol_cnt`=1, `first_viol`=9, `viol_seen`=1, `pass`=0.
  - Repeat with an error of exactly 1 at vectors 3 and 12 only → `max_err`=1, `viol_cnt`=0, `pass`=1 (boundary at ET).
- **Start while busy**: pulse `start` again during SWEEP at vector 7 → no restart; `done` still lands 17 edges after the original E0; a single `done` pulse.
- **Abort**:
  - `abort` at vector 5, with a fault at vector 2 of error 3 → IDLE next cycle, no `done`, `viol_cnt`=1, `max_err`=3, `pass`=0.
  - A following `start` clears all results and completes a normal sweep.
- **Reset mid-sweep**: drop `rst_n` asynchronously at vector 10 → all outputs 0 immediately, state IDLE, no `done`. A new `start` after reset release yields a correct full sweep.

Source files
------------

// File: rtl/approx_err_sweeper.sv
// approx_err_sweeper: exhaustively sweeps every input vector into an exact and
// an approximate combinational circuit. Their outputs are compared as unsigned
// integers, and the block tracks worst-case error, the violation count and the
// first violating vector. It reports pass/fail against the threshold ET.
module approx_err_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int ET    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  exact_in,
    input  logic [N_OUT-1:0]  approx_in,
    output logic              busy,
    output logic              done,
    output logic [N_OUT-1:0]  max_err,
    output logic [N_IN:0]     viol_cnt,
    output logic [N_IN-1:0]   first_viol,
    output logic              viol_seen,
    output logic              pass
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);
    localparam logic [N_IN:0]   CNT_ZERO = {(N_IN+1){1'b0}};
    localparam logic [31:0]     ET_W     = 32'(ET);

    // Absolute difference without overflow: larger operand minus smaller.
    function automatic logic [N_OUT-1:0] abs_diff(input logic [N_OUT-1:0] x,
                                                  input logic [N_OUT-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    state_t            state_r, state_next_s;
    logic              start_ok_s;
    logic              s1_valid_r;
    logic [N_OUT-1:0]  s1_exact_r, s1_approx_r;
    logic [N_IN-1:0]   s1_tag_r;
    logic [N_OUT-1:0]  err_s;
    logic              viol_s;
    logic [N_IN:0]     cnt_next_s;
    logic [N_OUT-1:0]  max_next_s;

    logic [N_IN-1:0]   vec_r;
    logic              busy_r, done_r, viol_seen_r, pass_r;
    logic [N_OUT-1:0]  max_err_r;
    logic [N_IN:0]     viol_cnt_r;
    logic [N_IN-1:0]   first_viol_r;

    // Next-state logic of the sweep sequencer.
    always_comb begin
        state_next_s = state_r;
        start_ok_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next_s = ST_SWEEP;
                    start_ok_s   = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (vec_r == VEC_LAST) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Stage-2 error evaluation for the vector held in stage 1.
    always_comb begin
        err_s      = abs_diff(s1_exact_r, s1_approx_r);
        viol_s     = s1_valid_r && ({{(32-N_OUT){1'b0}}, err_s} > ET_W);
        cnt_next_s = viol_cnt_r;
        max_next_s = max_err_r;
        if (viol_s) begin
            cnt_next_s = viol_cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = viol_cnt_r;
        end
        if (s1_valid_r && (err_s > max_err_r)) begin
            max_next_s = err_s;
        end else begin
            max_next_s = max_err_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Vector generator, stage-1 capture and busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r       <= {N_IN{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_exact_r  <= {N_OUT{1'b0}};
            s1_approx_r <= {N_OUT{1'b0}};
            s1_tag_r    <= {N_IN{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
            if ((state_r == ST_SWEEP) && !abort) begin
                s1_valid_r  <= 1'b1;
                s1_exact_r  <= exact_in;
                s1_approx_r <= approx_in;
                s1_tag_r    <= vec_r;
                // Wraps to 0 after the last vector and then holds in DRAIN.
                vec_r       <= vec_r + VEC_ONE;
            end else begin
                s1_valid_r  <= 1'b0;
                vec_r       <= {N_IN{1'b0}};
            end
        end
    end

    // Result accumulation, cleared on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err_r    <= {N_OUT{1'b0}};
            viol_cnt_r   <= CNT_ZERO;
            first_viol_r <= {N_IN{1'b0}};
            viol_seen_r  <= 1'b0;
            pass_r       <= 1'b0;
        end else if (start_ok_s) begin
            max_err_r    <= {N_OUT{1'b0}};
            viol_cnt_r   <= CNT_ZERO;
            first_viol_r <= {N_IN{1'b0}};
            viol_seen_r  <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            max_err_r  <= max_next_s;
            viol_cnt_r <= cnt_next_s;
            if (viol_s && !viol_seen_r) begin
                first_viol_r <= s1_tag_r;
                viol_seen_r  <= 1'b1;
            end
            // The last vector is accumulated on this same edge, so use the
            // updated count.
            if ((state_r == ST_DRAIN) && !abort) begin
                pass_r <= (cnt_next_s == CNT_ZERO);
            end
        end
    end

    assign vec_out    = vec_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign max_err    = max_err_r;
    assign viol_cnt   = viol_cnt_r;
    assign first_viol = first_viol_r;
    assign viol_seen  = viol_seen_r;
    assign pass       = pass_r;

endmodule

// File: tb/tb_approx_err_sweeper.sv
// Self-checking bench for approx_err_sweeper (N_IN=4, N_OUT=2, ET=1).
// The circuits under evaluation are lookup tables indexed by vec_out.
module tb_approx_err_sweeper;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [3:0] vec_out;
    logic [1:0] exact_in, approx_in;
    logic       busy, done, viol_seen, pass;
    logic [1:0] max_err;
    logic [4:0] viol_cnt;
    logic [3:0] first_viol;

    logic [1:0] ex_tab [0:15];
    logic [1:0] ap_tab [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string name;
        int    mode;
        int    e_max;
        int    e_cnt;
        int    e_first;
        int    e_seen;
        int    e_pass;
    } vec_t;

    vec_t tbl [4];

    approx_err_sweeper #(.N_IN(4), .N_OUT(2), .ET(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vec_out(vec_out), .exact_in(exact_in), .approx_in(approx_in),
        .busy(busy), .done(done), .max_err(max_err), .viol_cnt(viol_cnt),
        .first_viol(first_viol), .viol_seen(viol_seen), .pass(pass)
    );

    always #5 clk = ~clk;

    assign exact_in  = ex_tab[vec_out];
    assign approx_in = ap_tab[vec_out];

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Load the circuit pair for a named scenario.
    task automatic fill(input int mode);
        for (int v = 0; v < 16; v++) begin
            ex_tab[v] = 2'(v);
            ap_tab[v] = 2'(v);
            if (mode == 1) begin
                ex_tab[v] = 2'd3;
                ap_tab[v] = 2'd0;
            end
        end
        if (mode == 2) begin
            ex_tab[9] = 2'd2; ap_tab[9] = 2'd0;
        end
        if (mode == 3) begin
            ex_tab[3]  = 2'd3; ap_tab[3]  = 2'd2;
            ex_tab[12] = 2'd1; ap_tab[12] = 2'd0;
        end
        if (mode == 4) begin
            for (int v = 0; v < 16; v++) begin
                ex_tab[v] = 2'($urandom_range(0, 3));
                ap_tab[v] = 2'($urandom_range(0, 3));
            end
        end
    endtask

    // Reference: plain arithmetic over the whole truth table.
    task automatic model(output int m, output int c, output int f,
                         output int s, output int p);
        int e;
        m = 0; c = 0; f = 0; s = 0;
        for (int v = 0; v < 16; v++) begin
            e = int'(ex_tab[v]) - int'(ap_tab[v]);
            if (e < 0) e = -e;
            if (e > m) m = e;
            if (e > 1) begin
                c++;
                if (s == 0) begin f = v; s = 1; end
            end
        end
        p = (c == 0) ? 1 : 0;
    endtask

    task automatic chk_results(input string nm, input int m, input int c,
                               input int f, input int s, input int p);
        chk({nm, ".max_err"},  int'(max_err),  m);
        chk({nm, ".viol_cnt"}, int'(viol_cnt), c);
        if (s != 0) chk({nm, ".first_viol"}, int'(first_viol), f);
        chk({nm, ".viol_seen"}, int'(viol_seen), s);
        chk({nm, ".pass"},      int'(pass),      p);
    endtask

    // Start a sweep and observe 30 cycles; optionally re-pulse start at a vector.
    task automatic do_sweep(input string nm, input int restart_at);
        int done_cycle, done_count, busy_cnt;
        done_cycle = -1; done_count = 0; busy_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (restart_at >= 0 && busy && int'(vec_out) == restart_at)
                start = 1'b1;
            else
                start = 1'b0;
        end
        chk({nm, ".done_cycle"}, done_cycle, 18);
        chk({nm, ".done_count"}, done_count, 1);
        chk({nm, ".busy_cycles"}, busy_cnt, 18);
    endtask

    task automatic wait_vec(input int v, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (busy && int'(vec_out) == v) ok = 1'b1;
        end
    endtask

    initial begin
        int m, c, f, s, p, dn;
        bit ok;
        tbl[0] = '{"identity",   0, 0, 0,  0, 0, 1};
        tbl[1] = '{"all_fail",   1, 3, 16, 0, 1, 0};
        tbl[2] = '{"single_9",   2, 2, 1,  9, 1, 0};
        tbl[3] = '{"boundary_et",3, 1, 0,  0, 0, 1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        fill(0);
        #12;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.vec_out", int'(vec_out), 0);
        chk_results("reset", 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            fill(tbl[i].mode);
            do_sweep(tbl[i].name, -1);
            chk_results(tbl[i].name, tbl[i].e_max, tbl[i].e_cnt,
                        tbl[i].e_first, tbl[i].e_seen, tbl[i].e_pass);
        end

        // Start pulsed again mid-sweep must not restart it.
        fill(2);
        do_sweep("start_busy", 7);
        chk_results("start_busy", 2, 1, 9, 1, 0);

        // Random circuit pairs against the reference.
        for (int r = 0; r < 6; r++) begin
            fill(4);
            model(m, c, f, s, p);
            do_sweep("random", -1);
            chk_results("random", m, c, f, s, p);
        end

        // Abort at vector 5 with an error of 3 at vector 2.
        fill(0);
        ex_tab[2] = 2'd3; ap_tab[2] = 2'd0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_vec(5, ok);
        chk("abort.reach_vec5", int'(ok), 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort.busy", int'(busy), 0);
        chk("abort.vec_out", int'(vec_out), 0);
        dn = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort.no_done", dn, 0);
        chk_results("abort", 3, 1, 2, 1, 0);
        fill(0);
        do_sweep("after_abort", -1);
        chk_results("after_abort", 0, 0, 0, 0, 1);

        // Asynchronous reset at vector 10 of a failing sweep.
        fill(1);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_vec(10, ok);
        chk("rst_mid.reach_vec10", int'(ok), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", int'(busy), 0);
        chk("rst_mid.vec_out", int'(vec_out), 0);
        chk_results("rst_mid", 0, 0, 0, 0, 0);
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_mid.no_done", dn, 0);
        rst_n = 1'b1;
        fill(4);
        model(m, c, f, s, p);
        do_sweep("after_reset", -1);
        chk_results("after_reset", m, c, f, s, p);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
